jtag_tap_ctrl: RTL

//  IEEE 1149.1-style TAP controller for the JTAG board project. Sequences the 16-state TAP FSM

---
 rtl/jtag_pkg.sv | 30 +++
 rtl/jtag_tap_fsm.sv | 54 +++++
 rtl/jtag_tap_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, instruction opcodes and the IR capture pattern.
package jtag_pkg;

  typedef enum logic [3:0] {
    ST_EXIT2_DR  = 4'h0,
    ST_EXIT1_DR  = 4'h1,
    ST_SHIFT_DR  = 4'h2,
    ST_PAUSE_DR  = 4'h3,
    ST_SEL_IR    = 4'h4,
    ST_UPDATE_DR = 4'h5,
    ST_CAP_DR    = 4'h6,
    ST_SEL_DR    = 4'h7,
    ST_EXIT2_IR  = 4'h8,
    ST_EXIT1_IR  = 4'h9,
    ST_SHIFT_IR  = 4'hA,
    ST_PAUSE_IR  = 4'hB,
    ST_RTI       = 4'hC,
    ST_UPDATE_IR = 4'hD,
    ST_CAP_IR    = 4'hE,
    ST_TLR       = 4'hF
  } tap_state_t;

  localparam logic [3:0] OP_BYPASS      = 4'hF;
  localparam logic [3:0] OP_IDCODE      = 4'h1;
  localparam logic [3:0] OP_USER_LED    = 4'h8;
  localparam logic [3:0] OP_USER_STATUS = 4'h9;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP sequencer; strobes mark the state whose exiting rising edge performs the action.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_t state,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr
);

  tap_state_t next_state;

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) state <= ST_TLR;
    else      state <= next_state;
  end

  always_comb begin
    next_state = ST_TLR;
    case (state)
      ST_TLR:       next_state = TMS ? ST_TLR       : ST_RTI;
      ST_RTI:       next_state = TMS ? ST_SEL_DR    : ST_RTI;
      ST_SEL_DR:    next_state = TMS ? ST_SEL_IR    : ST_CAP_DR;
      ST_CAP_DR:    next_state = TMS ? ST_EXIT1_DR  : ST_SHIFT_DR;
      ST_SHIFT_DR:  next_state = TMS ? ST_EXIT1_DR  : ST_SHIFT_DR;
      ST_EXIT1_DR:  next_state = TMS ? ST_UPDATE_DR : ST_PAUSE_DR;
      ST_PAUSE_DR:  next_state = TMS ? ST_EXIT2_DR  : ST_PAUSE_DR;
      ST_EXIT2_DR:  next_state = TMS ? ST_UPDATE_DR : ST_SHIFT_DR;
      ST_UPDATE_DR: next_state = TMS ? ST_SEL_DR    : ST_RTI;
      ST_SEL_IR:    next_state = TMS ? ST_TLR       : ST_CAP_IR;
      ST_CAP_IR:    next_state = TMS ? ST_EXIT1_IR  : ST_SHIFT_IR;
      ST_SHIFT_IR:  next_state = TMS ? ST_EXIT1_IR  : ST_SHIFT_IR;
      ST_EXIT1_IR:  next_state = TMS ? ST_UPDATE_IR : ST_PAUSE_IR;
      ST_PAUSE_IR:  next_state = TMS ? ST_EXIT2_IR  : ST_PAUSE_IR;
      ST_EXIT2_IR:  next_state = TMS ? ST_UPDATE_IR : ST_SHIFT_IR;
      ST_UPDATE_IR: next_state = TMS ? ST_SEL_DR    : ST_RTI;
      default:      next_state = ST_TLR;
    endcase
  end

  assign capture_ir = (state == ST_CAP_IR);
  assign shift_ir   = (state == ST_SHIFT_IR);
  assign update_ir  = (state == ST_UPDATE_IR);
  assign capture_dr = (state == ST_CAP_DR);
  assign shift_dr   = (state == ST_SHIFT_DR);
  assign update_dr  = (state == ST_UPDATE_DR);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: IR, BYPASS/IDCODE/USER_LED/USER_STATUS data registers and
// the falling-edge TDO stage.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int                   IR_WIDTH   = 4,
  parameter logic [31:0]          IDCODE_VAL = 32'h1000_0001,
  parameter int                   LED_WIDTH  = 8,
  parameter logic [LED_WIDTH-1:0] LED_RESET  = 8'b01010101
) (
  input  logic                 TCK,
  input  logic                 TRST,
  input  logic                 TMS,
  input  logic                 TDI,
  output logic                 TDO,
  output logic                 TDO_EN,
  input  logic [LED_WIDTH-1:0] STATUS,
  output logic [LED_WIDTH-1:0] LED_PATTERN,
  output logic                 LED_UPDATE
);

  tap_state_t state;
  logic capture_ir, shift_ir, update_ir;
  logic capture_dr, shift_dr, update_dr;
  logic in_tlr;

  logic [IR_WIDTH-1:0]  ir;
  logic [IR_WIDTH-1:0]  ir_sr;
  logic                 bypass_sr;
  logic [31:0]          id_sr;
  logic [LED_WIDTH-1:0] user_sr;
  logic                 sel_idcode, sel_led, sel_status, sel_user;
  logic                 dr_lsb;

  jtag_tap_fsm u_fsm (
    .TCK        (TCK),
    .TRST       (TRST),
    .TMS        (TMS),
    .state      (state),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr)
  );

  assign in_tlr = (state == ST_TLR);

  // Unrecognised opcodes fall through to the bypass register.
  assign sel_idcode = (ir == IR_WIDTH'(OP_IDCODE));
  assign sel_led    = (ir == IR_WIDTH'(OP_USER_LED));
  assign sel_status = (ir == IR_WIDTH'(OP_USER_STATUS));
  assign sel_user   = sel_led | sel_status;

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_sr <= '0;
      ir    <= IR_WIDTH'(OP_IDCODE);
    end else begin
      if (capture_ir)    ir_sr <= IR_WIDTH'(IR_CAPTURE);
      else if (shift_ir) ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
      if (in_tlr)         ir <= IR_WIDTH'(OP_IDCODE);
      else if (update_ir) ir <= ir_sr;
    end
  end

  // USER_LED and USER_STATUS share one shift register; only USER_LED updates.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      bypass_sr <= 1'b0;
      id_sr     <= '0;
      user_sr   <= '0;
    end else if (capture_dr) begin
      bypass_sr <= 1'b0;
      if (sel_idcode) id_sr <= IDCODE_VAL;
      if (sel_led)         user_sr <= LED_PATTERN;
      else if (sel_status) user_sr <= STATUS;
    end else if (shift_dr) begin
      if (sel_idcode)    id_sr     <= {TDI, id_sr[31:1]};
      else if (sel_user) user_sr   <= {TDI, user_sr[LED_WIDTH-1:1]};
      else               bypass_sr <= TDI;
    end
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      LED_PATTERN <= LED_RESET;
      LED_UPDATE  <= 1'b0;
    end else begin
      LED_UPDATE <= update_dr & sel_led;
      if (in_tlr)                   LED_PATTERN <= LED_RESET;
      else if (update_dr & sel_led) LED_PATTERN <= user_sr;
    end
  end

  always_comb begin
    dr_lsb = bypass_sr;
    if (sel_idcode)    dr_lsb = id_sr[0];
    else if (sel_user) dr_lsb = user_sr[0];
  end

  // Output stage on the falling edge so TDO is stable across the next rising edge.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      TDO_EN <= shift_ir | shift_dr;
      if (shift_ir)      TDO <= ir_sr[0];
      else if (shift_dr) TDO <= dr_lsb;
      else               TDO <= 1'b0;
    end
  end

endmodule
